idma_obi_sim_mem: RTL and testbench

//  OBI subordinate memory model terminating an iDMA OBI manager port in the testbench.

---
 rtl/idma_obi_sim_mem.sv | 189 ++++++++++++++++++
 tb/tb_idma_obi_sim_mem.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/idma_obi_sim_mem.sv
// OBI subordinate memory model for terminating an iDMA OBI manager port in simulation.
// Grants with optional periodic stalls and queues in-order responses released after a fixed latency.

package idma_obi_sim_mem_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [3:0]  aid;
    } obi_a_chan_t;

    typedef struct packed {
        logic        a_req;
        obi_a_chan_t a;
        logic        r_ready;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [3:0]  rid;
        logic        err;
    } obi_r_chan_t;

    typedef struct packed {
        logic        a_gnt;
        logic        r_valid;
        obi_r_chan_t r;
    } obi_rsp_t;

endpackage

module idma_obi_sim_mem #(
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned IdWidth        = 4,
    parameter int unsigned MemWords       = 1024,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned RespLatency    = 2,
    parameter int unsigned GntStallPeriod = 0,
    parameter type obi_req_t = idma_obi_sim_mem_pkg::obi_req_t,
    parameter type obi_rsp_t = idma_obi_sim_mem_pkg::obi_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  obi_req_t obi_req_i,
    output obi_rsp_t obi_rsp_o
);

    localparam int unsigned NumBytes = DataWidth / 8;
    localparam int unsigned OffW     = $clog2(NumBytes);
    localparam int unsigned IdxW     = (MemWords > 1) ? $clog2(MemWords) : 1;
    localparam int unsigned PtrW     = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW     = $clog2(MaxOutstanding + 1);
    localparam int unsigned AgeW     = $clog2(RespLatency + 1);

    logic [AddrWidth-1:0] word_s;
    logic                 in_range_s;
    logic                 full_s;
    logic                 stall_s;
    logic                 gnt_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 r_valid_s;
    logic [DataWidth-1:0] rsp_rdata_s;
    logic                 rsp_err_s;

    logic [DataWidth-1:0] mem_r   [MemWords];
    logic [DataWidth-1:0] rdata_r [MaxOutstanding];
    logic [IdWidth-1:0]   rid_r   [MaxOutstanding];
    logic                 err_r   [MaxOutstanding];
    logic [AgeW-1:0]      age_r   [MaxOutstanding];
    logic [PtrW-1:0]      rd_ptr_r;
    logic [PtrW-1:0]      wr_ptr_r;
    logic [CntW-1:0]      count_r;

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] ptr);
        if (ptr == PtrW'(MaxOutstanding - 1)) begin
            return {PtrW{1'b0}};
        end else begin
            return ptr + PtrW'(1);
        end
    endfunction

    assign word_s     = obi_req_i.a.addr >> OffW;
    assign in_range_s = (word_s < AddrWidth'(MemWords));
    assign full_s     = (count_r == CntW'(MaxOutstanding));
    // Gated by reset so the grant stays low while the model is held in reset.
    assign gnt_s      = rst_ni & obi_req_i.a_req & ~full_s & ~stall_s;
    assign push_s     = gnt_s;
    assign r_valid_s  = (count_r != {CntW{1'b0}}) && (age_r[rd_ptr_r] == AgeW'(RespLatency));
    assign pop_s      = r_valid_s & obi_req_i.r_ready;

    if (GntStallPeriod > 0) begin : gen_stall
        localparam int unsigned StallW = (GntStallPeriod > 1) ? $clog2(GntStallPeriod) : 1;
        logic [StallW-1:0] stall_cnt_r;

        // Free-running stall phase counter, independent of a_req
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                stall_cnt_r <= {StallW{1'b0}};
            end else if (stall_cnt_r == StallW'(GntStallPeriod - 1)) begin
                stall_cnt_r <= {StallW{1'b0}};
            end else begin
                stall_cnt_r <= stall_cnt_r + StallW'(1);
            end
        end

        assign stall_s = (stall_cnt_r == StallW'(GntStallPeriod - 1));
    end else begin : gen_no_stall
        assign stall_s = 1'b0;
    end

    // Response payload for the transaction being granted this cycle
    always_comb begin
        rsp_rdata_s = {DataWidth{1'b0}};
        rsp_err_s   = 1'b0;
        if (!in_range_s) begin
            rsp_err_s = 1'b1;
        end else if (!obi_req_i.a.we) begin
            rsp_rdata_s = mem_r[word_s[IdxW-1:0]];
        end else begin
            rsp_rdata_s = {DataWidth{1'b0}};
        end
    end

    // Backing memory with byte-enabled writes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MemWords; i++) begin
                mem_r[i] <= {DataWidth{1'b0}};
            end
        end else if (push_s && obi_req_i.a.we && in_range_s) begin
            for (int b = 0; b < NumBytes; b++) begin
                if (obi_req_i.a.be[b]) begin
                    mem_r[word_s[IdxW-1:0]][8*b +: 8] <= obi_req_i.a.wdata[8*b +: 8];
                end
            end
        end
    end

    // In-order response FIFO with per-entry age; a fresh entry's age overrides the saturating increment
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_r <= {PtrW{1'b0}};
            wr_ptr_r <= {PtrW{1'b0}};
            count_r  <= {CntW{1'b0}};
            for (int i = 0; i < MaxOutstanding; i++) begin
                rdata_r[i] <= {DataWidth{1'b0}};
                rid_r[i]   <= {IdWidth{1'b0}};
                err_r[i]   <= 1'b0;
                age_r[i]   <= {AgeW{1'b0}};
            end
        end else begin
            for (int i = 0; i < MaxOutstanding; i++) begin
                if (age_r[i] != AgeW'(RespLatency)) begin
                    age_r[i] <= age_r[i] + AgeW'(1);
                end
            end
            if (push_s) begin
                rdata_r[wr_ptr_r] <= rsp_rdata_s;
                rid_r[wr_ptr_r]   <= obi_req_i.a.aid;
                err_r[wr_ptr_r]   <= rsp_err_s;
                age_r[wr_ptr_r]   <= AgeW'(1);
                wr_ptr_r          <= ptr_next(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CntW'(1);
                2'b01:   count_r <= count_r - CntW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Response channel driven from the FIFO head
    always_comb begin
        obi_rsp_o         = '0;
        obi_rsp_o.a_gnt   = gnt_s;
        obi_rsp_o.r_valid = r_valid_s;
        obi_rsp_o.r.rdata = rdata_r[rd_ptr_r];
        obi_rsp_o.r.rid   = rid_r[rd_ptr_r];
        obi_rsp_o.r.err   = err_r[rd_ptr_r];
    end

endmodule

// File: tb/tb_idma_obi_sim_mem.sv
// Self-checking bench for idma_obi_sim_mem: reset, directed vector table, backpressure,
// randomized traffic against a transaction-level model, grant stalls and mid-traffic reset.
module tb_idma_obi_sim_mem;
    import idma_obi_sim_mem_pkg::*;

    localparam int Lat    = 2;
    localparam int MaxOut = 4;
    localparam int Words  = 1024;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [3:0]  aid;
    } txn_t;

    typedef struct {
        logic [31:0] rdata;
        logic [3:0]  rid;
        logic        err;
        int          gcyc;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [3:0]  aid;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic     clk = 1'b0;
    logic     rst_n;
    obi_req_t req0, req1;
    obi_rsp_t rsp0, rsp1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dut_grants = 0;

    txn_t        pend_q[$];
    rsp_t        mq[$];
    rsp_t        got_q[$];
    logic [31:0] ref_mem [Words];

    always #5 clk = ~clk;

    idma_obi_sim_mem #(.MaxOutstanding(MaxOut), .RespLatency(Lat), .GntStallPeriod(0), .MemWords(Words)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .obi_req_i(req0), .obi_rsp_o(rsp0));

    idma_obi_sim_mem #(.MaxOutstanding(MaxOut), .RespLatency(Lat), .GntStallPeriod(3), .MemWords(64)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .obi_req_i(req1), .obi_rsp_o(rsp1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic txn_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input logic [3:0] aid);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata; t.be = be; t.aid = aid;
        return t;
    endfunction

    // One clock cycle on dut0: drive head of pend_q, check against the model, then advance the model.
    task automatic step(input logic rr);
        txn_t        t;
        rsp_t        e;
        rsp_t        g;
        logic        egnt, erv;
        int unsigned w;
        logic [31:0] mask;
        if (pend_q.size() > 0) begin
            t = pend_q[0];
            req0.a_req   = 1'b1;
            req0.a.we    = t.we;
            req0.a.addr  = t.addr;
            req0.a.wdata = t.wdata;
            req0.a.be    = t.be;
            req0.a.aid   = t.aid;
        end else begin
            req0.a_req = 1'b0;
        end
        req0.r_ready = rr;
        @(negedge clk);
        egnt = (pend_q.size() > 0) && (mq.size() < MaxOut);
        erv  = (mq.size() > 0) && ((cyc - mq[0].gcyc) >= Lat);
        chk("a_gnt", rsp0.a_gnt, egnt);
        chk("r_valid", rsp0.r_valid, erv);
        if (erv) begin
            chk("r_rdata", rsp0.r.rdata, mq[0].rdata);
            chk("r_rid", rsp0.r.rid, mq[0].rid);
            chk("r_err", rsp0.r.err, mq[0].err);
        end
        if (rsp0.a_gnt && req0.a_req) dut_grants++;
        if (rsp0.r_valid && rr) begin
            g.rdata = rsp0.r.rdata; g.rid = rsp0.r.rid; g.err = rsp0.r.err; g.gcyc = cyc;
            got_q.push_back(g);
        end
        @(posedge clk);
        if (erv && rr) void'(mq.pop_front());
        if (egnt) begin
            t = pend_q.pop_front();
            w = t.addr / 4;
            e.rid = t.aid; e.gcyc = cyc; e.rdata = 32'h0; e.err = (w >= Words);
            if (!e.err) begin
                if (t.we) begin
                    mask = 32'h0;
                    for (int b = 0; b < 4; b++) if (t.be[b]) mask = mask | (32'hFF << (8 * b));
                    ref_mem[w] = (ref_mem[w] & ~mask) | (t.wdata & mask);
                end else begin
                    e.rdata = ref_mem[w];
                end
            end
            mq.push_back(e);
        end
        cyc++;
        #1;
    endtask

    vec_t vecs[11];

    initial begin
        int g0;
        int ng;
        txn_t rt;

        vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 4'd3,  32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'hF, 4'd5,  32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h20,   32'h11223344, 4'h5, 4'd1,  32'h0,        1'b0};
        vecs[3]  = '{1'b0, 32'h20,   32'h0,        4'hF, 4'd2,  32'h00220044, 1'b0};
        vecs[4]  = '{1'b0, 32'h1000, 32'h0,        4'hF, 4'd7,  32'h0,        1'b1};
        vecs[5]  = '{1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 4'd8,  32'h0,        1'b1};
        vecs[6]  = '{1'b0, 32'h0,    32'h0,        4'hF, 4'd9,  32'h0,        1'b0};
        vecs[7]  = '{1'b1, 32'hFFC,  32'hA5A5A5A5, 4'h8, 4'd10, 32'h0,        1'b0};
        vecs[8]  = '{1'b0, 32'hFFC,  32'h0,        4'hF, 4'd11, 32'hA5000000, 1'b0};
        vecs[9]  = '{1'b1, 32'h10,   32'h0000FFFF, 4'h3, 4'd12, 32'h0,        1'b0};
        vecs[10] = '{1'b0, 32'h10,   32'h0,        4'hF, 4'd13, 32'hDEADFFFF, 1'b0};

        for (int i = 0; i < Words; i++) ref_mem[i] = 32'h0;
        req0 = '0;
        req1 = '0;
        rst_n = 1'b0;
        req0.a_req = 1'b1;
        req1.a_req = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_gnt0", rsp0.a_gnt, 1'b0);
        chk("reset_rvalid0", rsp0.r_valid, 1'b0);
        chk("reset_rdata0", rsp0.r.rdata, 32'h0);
        chk("reset_rid0", rsp0.r.rid, 4'h0);
        chk("reset_err0", rsp0.r.err, 1'b0);
        chk("reset_gnt1", rsp1.a_gnt, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req1.a_req = 1'b0;
        cyc = 0;

        // Grant in the first cycle after release
        pend_q.push_back(mk(1'b0, 32'h4, 32'h0, 4'hF, 4'd0));
        step(1'b1);
        repeat (6) step(1'b1);

        // Directed vector table
        got_q.delete();
        foreach (vecs[i]) pend_q.push_back(mk(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].aid));
        repeat (11 + 10) step(1'b1);
        chk("tbl_count", got_q.size(), 11);
        for (int i = 0; i < 11 && i < got_q.size(); i++) begin
            chk($sformatf("tbl%0d_rdata", i), got_q[i].rdata, vecs[i].exp_rdata);
            chk($sformatf("tbl%0d_rid", i), got_q[i].rid, vecs[i].aid);
            chk($sformatf("tbl%0d_err", i), got_q[i].err, vecs[i].exp_err);
        end

        // Backpressure: six reads against a four-deep response queue
        g0 = dut_grants;
        got_q.delete();
        for (int i = 0; i < 6; i++) pend_q.push_back(mk(1'b0, 32'h10 * i, 32'h0, 4'hF, 4'(i)));
        repeat (10) step(1'b0);
        chk("full_grants", dut_grants - g0, 4);
        chk("full_gnt_low", rsp0.a_gnt, 1'b0);
        repeat (16) step(1'b1);
        chk("full_total_grants", dut_grants - g0, 6);
        chk("full_rsp_count", got_q.size(), 6);
        for (int i = 0; i < 6 && i < got_q.size(); i++) chk($sformatf("full_order%0d", i), got_q[i].rid, i);

        // Randomized traffic against the model
        repeat (400) begin
            if (pend_q.size() < 2 && $urandom_range(0, 1) == 1) begin
                rt.we    = 1'($urandom_range(0, 1));
                rt.addr  = ($urandom_range(0, 7) == 0) ? 32'h1000 + 4 * $urandom_range(0, 15)
                                                       : 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
                rt.wdata = $urandom;
                rt.be    = 4'($urandom_range(0, 15));
                rt.aid   = 4'($urandom_range(0, 15));
                pend_q.push_back(rt);
            end
            step($urandom_range(0, 3) != 0);
        end
        repeat (12) step(1'b1);

        // Grant stall pattern on dut1 (period 3)
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req1.a_req = 1'b1; req1.r_ready = 1'b1; req1.a.we = 1'b0; req1.a.addr = 32'h8; req1.a.be = 4'hF;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk($sformatf("stall_gnt%0d", i), rsp1.a_gnt, (i % 3) != 2);
            @(posedge clk);
            #1;
        end
        req1.a_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Reset with two responses queued must drop them
        req1.r_ready = 1'b0;
        req1.a_req = 1'b1;
        ng = 0;
        for (int n = 0; n < 12 && ng < 2; n++) begin
            @(negedge clk);
            if (rsp1.a_gnt) ng++;
            @(posedge clk);
            #1;
        end
        req1.a_req = 1'b0;
        chk("rstq_grants", ng, 2);
        repeat (3) @(posedge clk);
        #1;
        chk("rstq_valid_before", rsp1.r_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rstq_async_rvalid", rsp1.r_valid, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req1.r_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("rstq_no_stale%0d", i), rsp1.r_valid, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
